// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder fetching words over req/ack and presenting them to decode over valid/ready
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;
  state_t      state;
  logic [31:0] pc;
  logic        ack, xfer, misal, pend;
  always_comb begin
    ack   = mem_req && mem_ack;
    xfer  = instr_valid && instr_ready;
    misal = redirect_pc[1:0] != 2'b00;
    pend  = mem_req && !mem_ack;
  end
  // A request still waiting for its ack must be held; DRAIN and HALT just wait it out and drop the data
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else if (state != HALT && redirect_valid) begin
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      mem_req     <= pend;
      state       <= misal ? HALT : pend ? DRAIN : FETCH;
      if (misal) fetch_fault <= 1'b1;
    end else if (state == FETCH) begin
      if (ack) begin
        instr       <= mem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + 32'd4;
        mem_req     <= 1'b0;
      end else begin
        if (xfer) begin
          instr_valid <= 1'b0;
          instr       <= NOP_INSTR;
        end
        if (!mem_req && (!instr_valid || instr_ready)) begin
          mem_req  <= 1'b1;
          mem_addr <= pc;
        end
      end
      if (xfer) fetch_count <= fetch_count + 32'd1;
    end else if (ack) begin
      mem_req <= 1'b0;
      state   <= state == DRAIN ? FETCH : HALT;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenario tasks against a wait-state memory model
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_req, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_rdata = 32'd0;
  logic [31:0] instr, instr_pc, fetch_count;
  logic        instr_valid, instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        fetch_fault;
  int n_chk = 0, n_fail = 0;
  int waits = 0, cnt = 0;
  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rd(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h00A0_0113 : (a << 12) | 32'h13;
  endfunction
  // Memory acks after `waits` idle request cycles; driven 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (rst || !mem_req || mem_ack) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (cnt >= waits) begin
      mem_ack = 1'b1;
      mem_rdata = rd(mem_addr);
    end else cnt++;
  end
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %h want 0", mem_req); end
    n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %h want 0", instr_valid); end
    n_chk++; if (instr !== NOP) begin n_fail++; $display("FAIL rst_instr got %h want %h", instr, NOP); end
    n_chk++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
    n_chk++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault got %h want 0", fetch_fault); end
    n_chk++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL rst_count got %h want 0", fetch_count); end
  endtask
  task automatic test_basic;
    rst = 1'b0;
    tick;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_req0 got %h/%h want 1/0", mem_req, mem_addr); end
    tick;
    n_chk++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL basic_w0 got %h/%h/%h want 1/00500093/0", instr_valid, instr, instr_pc); end
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_gap got %h want 0", mem_req); end
    instr_ready = 1'b1;
    tick;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || fetch_count !== 32'd1) begin n_fail++; $display("FAIL basic_req1 got %h/%h/%h want 1/4/1", mem_req, mem_addr, fetch_count); end
    tick;
    n_chk++; if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || instr_pc !== 32'h4) begin n_fail++; $display("FAIL basic_w1 got %h/%h/%h want 1/00a00113/4", instr_valid, instr, instr_pc); end
    tick;
    n_chk++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL basic_count got %h want 2", fetch_count); end
    instr_ready = 1'b0;
    tick;
    n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin n_fail++; $display("FAIL basic_w2 got %h/%h want 1/8", instr_valid, instr_pc); end
  endtask
  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_chk++; if (instr_valid !== 1'b1 || instr !== 32'h0000_8013 || mem_req !== 1'b0 || fetch_count !== 32'd2) begin n_fail++; $display("FAIL bp_hold%0d got %h/%h/%h/%h want 1/00008013/0/2", i, instr_valid, instr, mem_req, fetch_count); end
    end
    instr_ready = 1'b1;
    tick;
    n_chk++; if (fetch_count !== 32'd3 || instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'hC) begin n_fail++; $display("FAIL bp_xfer got %h/%h/%h/%h want 3/0/1/c", fetch_count, instr_valid, mem_req, mem_addr); end
    instr_ready = 1'b0;
    tick;
    n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC || fetch_count !== 32'd3) begin n_fail++; $display("FAIL bp_once got %h/%h/%h want 1/c/3", instr_valid, instr_pc, fetch_count); end
  endtask
  task automatic test_redirect_mid;
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick;
    n_chk++; if (instr_valid !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL rdm_flush got %h/%h want 0/%h", instr_valid, instr, NOP); end
    redirect_valid = 1'b0; waits = 3; instr_ready = 1'b1;
    tick;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin n_fail++; $display("FAIL rdm_req8 got %h/%h want 1/8", mem_req, mem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick;
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdm_drain%0d got %h/%h/%h want 1/8/0", i, mem_req, mem_addr, instr_valid); end
      tick;
    end
    n_chk++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdm_drop got %h/%h want 0/0", mem_req, instr_valid); end
    waits = 0;
    tick;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL rdm_req100 got %h/%h want 1/100", mem_req, mem_addr); end
    tick;
    n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h0010_0013 || fetch_count !== 32'd3) begin n_fail++; $display("FAIL rdm_first got %h/%h/%h/%h want 1/100/00100013/3", instr_valid, instr_pc, instr, fetch_count); end
    tick;
    n_chk++; if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL rdm_count got %h want 4", fetch_count); end
  endtask
  task automatic test_redirect_ack;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick;
    redirect_valid = 1'b0;
    n_chk++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || fetch_count !== 32'd4) begin n_fail++; $display("FAIL rda_drop got %h/%h/%h want 0/0/4", instr_valid, mem_req, fetch_count); end
    tick;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL rda_req got %h/%h want 1/40", mem_req, mem_addr); end
    tick;
    n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h0004_0013) begin n_fail++; $display("FAIL rda_word got %h/%h/%h want 1/40/00040013", instr_valid, instr_pc, instr); end
    tick;
    n_chk++; if (fetch_count !== 32'd5) begin n_fail++; $display("FAIL rda_count got %h want 5", fetch_count); end
    instr_ready = 1'b0;
    tick;
  endtask
  task automatic test_misaligned;
    tick;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick;
    n_chk++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || mem_req !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL mis_fault got %h/%h/%h/%h want 1/0/0/%h", fetch_fault, instr_valid, mem_req, instr, NOP); end
    redirect_pc = 32'h200; instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_chk++; if (mem_req !== 1'b0 || fetch_fault !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL mis_halt%0d got %h/%h/%h want 0/1/0", i, mem_req, fetch_fault, instr_valid); end
    end
    redirect_valid = 1'b0; rst = 1'b1;
    tick;
    n_chk++; if (fetch_fault !== 1'b0 || mem_addr !== 32'h0 || mem_req !== 1'b0 || fetch_count !== 32'd0) begin n_fail++; $display("FAIL mis_rst got %h/%h/%h/%h want 0/0/0/0", fetch_fault, mem_addr, mem_req, fetch_count); end
  endtask
  task automatic test_wrap;
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; instr_ready = 1'b1;
    tick;
    redirect_valid = 1'b0;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_idle got %h want 0", mem_req); end
    tick;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req got %h/%h want 1/fffffffc", mem_req, mem_addr); end
    tick;
    n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_word got %h/%h want 1/fffffffc", instr_valid, instr_pc); end
    tick;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || fetch_count !== 32'd1) begin n_fail++; $display("FAIL wrap_next got %h/%h/%h want 1/0/1", mem_req, mem_addr, fetch_count); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_redirect_mid;
    test_redirect_ack;
    test_misaligned;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
